// File: rtl/io_instr_sequencer_if.sv
// Control interface of the fetch / port-I/O sequencer.
// The master side (instruction register / memory model) drives run,
// mem_ready and ir_opcode; the slave side (the sequencer) drives the
// datapath strobes and status.
// Handshake: in T1 the sequencer holds read high every cycle; a T1 cycle
// with mem_ready = 1 completes the read and the MDR latches on that edge.
// mem_ready is ignored in every other state.
interface io_instr_sequencer_if #(
  parameter int OPCODE_W = 5
) ();
  logic                run;
  logic                mem_ready;
  logic [OPCODE_W-1:0] ir_opcode;
  logic PCout, MARIn, IncPC, ZIn;
  logic Zlowout, PCIn, MDRIn, read;
  logic MDRout, IRIn;
  logic Gra, Rout, OutIn, RIn, IN_Portout;
  logic       instr_done;
  logic       err;
  logic [1:0] err_code;
  logic [2:0] t_state;

  modport master (
    output run, mem_ready, ir_opcode,
    input  PCout, MARIn, IncPC, ZIn, Zlowout, PCIn, MDRIn, read,
           MDRout, IRIn, Gra, Rout, OutIn, RIn, IN_Portout,
           instr_done, err, err_code, t_state
  );

  modport slave (
    input  run, mem_ready, ir_opcode,
    output PCout, MARIn, IncPC, ZIn, Zlowout, PCIn, MDRIn, read,
           MDRout, IRIn, Gra, Rout, OutIn, RIn, IN_Portout,
           instr_done, err, err_code, t_state
  );
endinterface

// File: rtl/io_instr_sequencer.sv
// Fetch / execute control sequencer for the `in` and `out` instructions.
// Steps T0..T3, stretches T1 with memory wait states (bus timeout),
// honours run/stop between instructions and traps illegal opcodes in a
// sticky ERR state. All strobes are Moore decodes of the state register.
// Optional macro INSTR_COUNT_EN adds a 32-bit retired-instruction counter
// output instr_count.
module io_instr_sequencer #(
  parameter int                OPCODE_W    = 5,
  parameter logic [OPCODE_W-1:0] OP_IN     = 5'b10110,
  parameter logic [OPCODE_W-1:0] OP_OUT    = 5'b10111,
  parameter int                MEM_TIMEOUT = 15,
  parameter int                TMO_W       = 4
) (
  input  logic               clk,
  input  logic               clr,
  io_instr_sequencer_if.slave bus
`ifdef INSTR_COUNT_EN
  ,
  output logic [31:0]        instr_count
`endif
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_T0   = 3'd1,
    S_T1   = 3'd2,
    S_T2   = 3'd3,
    S_T3   = 3'd4,
    S_ERR  = 3'd7
  } state_t;

  // Counter value seen in the last T1 cycle allowed before the timeout fires:
  // MEM_TIMEOUT T1 cycles without mem_ready in total.
  localparam logic [TMO_W-1:0] TMO_LAST =
    TMO_W'((MEM_TIMEOUT == 0) ? 0 : (MEM_TIMEOUT - 1));

  state_t           state;
  state_t           state_nxt;
  logic [TMO_W-1:0] wait_cnt;
  logic             first_t1;
  logic             err_q;
  logic [1:0]       err_code_q;
  logic             op_in;
  logic             op_out;
  logic             tmo_hit;

  assign op_in   = (bus.ir_opcode == OP_IN);
  assign op_out  = (bus.ir_opcode == OP_OUT);
  assign tmo_hit = (MEM_TIMEOUT != 0) && !bus.mem_ready && (wait_cnt == TMO_LAST);

  // State register.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // Next-state decode.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (bus.run) state_nxt = S_T0;
      S_T0:   state_nxt = S_T1;
      S_T1: begin
        if (bus.mem_ready) state_nxt = S_T2;
        else if (tmo_hit)  state_nxt = S_ERR;
      end
      S_T2:   state_nxt = S_T3;
      S_T3: begin
        if (!(op_in || op_out)) state_nxt = S_ERR;
        else if (bus.run)       state_nxt = S_T0;
        else                    state_nxt = S_IDLE;
      end
      S_ERR:  state_nxt = S_ERR;
      default: state_nxt = S_ERR;
    endcase
  end

  // Moore strobe decode from the registered state.
  always_comb begin
    bus.PCout      = 1'b0;
    bus.MARIn      = 1'b0;
    bus.IncPC      = 1'b0;
    bus.ZIn        = 1'b0;
    bus.Zlowout    = 1'b0;
    bus.PCIn       = 1'b0;
    bus.MDRIn      = 1'b0;
    bus.read       = 1'b0;
    bus.MDRout     = 1'b0;
    bus.IRIn       = 1'b0;
    bus.Gra        = 1'b0;
    bus.Rout       = 1'b0;
    bus.OutIn      = 1'b0;
    bus.RIn        = 1'b0;
    bus.IN_Portout = 1'b0;
    bus.instr_done = 1'b0;
    case (state)
      S_T0: begin
        bus.PCout = 1'b1;
        bus.MARIn = 1'b1;
        bus.IncPC = 1'b1;
        bus.ZIn   = 1'b1;
      end
      S_T1: begin
        bus.read    = 1'b1;
        bus.MDRIn   = 1'b1;
        bus.Zlowout = first_t1;
        bus.PCIn    = first_t1;
      end
      S_T2: begin
        bus.MDRout = 1'b1;
        bus.IRIn   = 1'b1;
      end
      S_T3: begin
        if (op_out) begin
          bus.Gra        = 1'b1;
          bus.Rout       = 1'b1;
          bus.OutIn      = 1'b1;
          bus.instr_done = 1'b1;
        end else if (op_in) begin
          bus.Gra        = 1'b1;
          bus.IN_Portout = 1'b1;
          bus.RIn        = 1'b1;
          bus.instr_done = 1'b1;
        end
      end
      default: ;
    endcase
  end

  // Wait-state counter, first-T1 flag and sticky error capture.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      wait_cnt   <= '0;
      first_t1   <= 1'b1;
      err_q      <= 1'b0;
      err_code_q <= 2'd0;
    end else begin
      if (state == S_T1 && !bus.mem_ready && !tmo_hit) wait_cnt <= wait_cnt + 1'b1;
      else                                             wait_cnt <= '0;

      if (state == S_T0)      first_t1 <= 1'b1;
      else if (state == S_T1) first_t1 <= 1'b0;

      if (state != S_ERR && state_nxt == S_ERR) begin
        err_q      <= 1'b1;
        err_code_q <= (state == S_T1) ? 2'd1 : 2'd2;
      end
    end
  end

  assign bus.err      = err_q;
  assign bus.err_code = err_code_q;
  assign bus.t_state  = state;

`ifdef INSTR_COUNT_EN
  // Retired-instruction counter; wraps naturally at 32 bits.
  always_ff @(posedge clk or posedge clr) begin
    if (clr)                 instr_count <= 32'd0;
    else if (bus.instr_done) instr_count <= instr_count + 32'd1;
  end
`endif

endmodule

// File: tb/tb_io_instr_sequencer.sv
// Directed bench for io_instr_sequencer: reset, OUT zero-wait, IN with
// three wait states, stop via run, async clear mid-instruction, illegal
// opcode, back-to-back issue and bus timeout. With INSTR_COUNT_EN the
// retired-instruction counter is checked as well.
module tb_io_instr_sequencer;

  localparam logic [4:0] OP_IN  = 5'b10110;
  localparam logic [4:0] OP_OUT = 5'b10111;
  localparam logic [4:0] OP_ILL = 5'b00011;

  // Strobe vector order:
  // PCout MARIn IncPC ZIn | Zlowout PCIn MDRIn read | MDRout IRIn | Gra Rout OutIn RIn IN_Portout
  localparam logic [14:0] S_NONE = 15'b0000_0000_00_00000;
  localparam logic [14:0] S_T0   = 15'b1111_0000_00_00000;
  localparam logic [14:0] S_T1F  = 15'b0000_1111_00_00000;
  localparam logic [14:0] S_T1   = 15'b0000_0011_00_00000;
  localparam logic [14:0] S_T2   = 15'b0000_0000_11_00000;
  localparam logic [14:0] S_OUT  = 15'b0000_0000_00_11100;
  localparam logic [14:0] S_IN   = 15'b0000_0000_00_10011;

  // ---------------- clock / reset ----------------
  logic clk;
  logic clr;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  io_instr_sequencer_if #(.OPCODE_W(5)) sif ();

`ifdef INSTR_COUNT_EN
  logic [31:0] instr_count;
  io_instr_sequencer dut (.clk(clk), .clr(clr), .bus(sif), .instr_count(instr_count));
`else
  io_instr_sequencer dut (.clk(clk), .clr(clr), .bus(sif));
`endif

  logic [14:0] strb;
  assign strb = {sif.PCout, sif.MARIn, sif.IncPC, sif.ZIn,
                 sif.Zlowout, sif.PCIn, sif.MDRIn, sif.read,
                 sif.MDRout, sif.IRIn,
                 sif.Gra, sif.Rout, sif.OutIn, sif.RIn, sif.IN_Portout};

  int checks   = 0;
  int failures = 0;

  // ---------------- checking helpers ----------------
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock, then check state, strobes and instr_done.
  task automatic cyc(input string tag, input logic [2:0] st, input logic [14:0] s,
                     input logic done);
    @(posedge clk);
    #1;
    chk({tag, "_state"}, 32'(sif.t_state), 32'(st));
    chk({tag, "_strb"},  32'(strb), 32'(s));
    chk({tag, "_done"},  32'(sif.instr_done), 32'(done));
  endtask

  task automatic chk_err(input string tag, input logic e, input logic [1:0] code);
    chk({tag, "_err"},  32'(sif.err), 32'(e));
    chk({tag, "_code"}, 32'(sif.err_code), 32'(code));
  endtask

  task automatic chk_cnt(input string tag, input logic [31:0] exp);
`ifdef INSTR_COUNT_EN
    chk({tag, "_count"}, instr_count, exp);
`else
    if (tag.len() > 0 && exp == 32'hFFFF_FFFF) $display("note: %s", tag);
`endif
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "bench did not finish");
  end

  // ---------------- directed sequence ----------------
  initial begin
    clr = 1'b1;
    sif.run = 1'b1;
    sif.mem_ready = 1'b1;
    sif.ir_opcode = OP_OUT;

    // Reset held for 3 cycles with run = 1.
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      chk("rst_state", 32'(sif.t_state), 32'd0);
      chk("rst_strb",  32'(strb), 32'(S_NONE));
      chk("rst_done",  32'(sif.instr_done), 32'd0);
      chk_err("rst", 1'b0, 2'd0);
    end
    chk_cnt("rst", 32'd0);
    clr = 1'b0;

    // OUT, zero wait states, back-to-back into the next fetch.
    cyc("out0_t0", 3'd1, S_T0, 1'b0);
    cyc("out0_t1", 3'd2, S_T1F, 1'b0);
    cyc("out0_t2", 3'd3, S_T2, 1'b0);
    cyc("out0_t3", 3'd4, S_OUT, 1'b1);
    chk_cnt("out0_t3", 32'd0);
    sif.mem_ready = 1'b0;
    sif.ir_opcode = OP_IN;

    // IN with 3 wait states; mem_ready rises in the 4th T1 cycle.
    cyc("in_t0", 3'd1, S_T0, 1'b0);
    chk_cnt("in_t0", 32'd1);
    cyc("in_t1a", 3'd2, S_T1F, 1'b0);
    cyc("in_t1b", 3'd2, S_T1, 1'b0);
    cyc("in_t1c", 3'd2, S_T1, 1'b0);
    cyc("in_t1d", 3'd2, S_T1, 1'b0);
    sif.mem_ready = 1'b1;
    cyc("in_t2", 3'd3, S_T2, 1'b0);
    cyc("in_t3", 3'd4, S_IN, 1'b1);
    sif.ir_opcode = OP_OUT;

    // Drop run during T1: instruction completes, then IDLE.
    cyc("stop_t0", 3'd1, S_T0, 1'b0);
    chk_cnt("stop_t0", 32'd2);
    cyc("stop_t1", 3'd2, S_T1F, 1'b0);
    sif.run = 1'b0;
    cyc("stop_t2", 3'd3, S_T2, 1'b0);
    cyc("stop_t3", 3'd4, S_OUT, 1'b1);
    cyc("stop_idle", 3'd0, S_NONE, 1'b0);
    chk_cnt("stop_idle", 32'd3);
    cyc("stop_idle2", 3'd0, S_NONE, 1'b0);

    // Restart, then async clear during T2.
    sif.run = 1'b1;
    cyc("rs_t0", 3'd1, S_T0, 1'b0);
    cyc("rs_t1", 3'd2, S_T1F, 1'b0);
    cyc("rs_t2", 3'd3, S_T2, 1'b0);
    #1;
    clr = 1'b1;
    #1;
    chk("clr_state", 32'(sif.t_state), 32'd0);
    chk("clr_strb",  32'(strb), 32'(S_NONE));
    chk_cnt("clr", 32'd0);
    clr = 1'b0;

    // Illegal opcode: T3 with no strobes, then sticky ERR code 2.
    sif.ir_opcode = OP_ILL;
    cyc("ill_t0", 3'd1, S_T0, 1'b0);
    cyc("ill_t1", 3'd2, S_T1F, 1'b0);
    cyc("ill_t2", 3'd3, S_T2, 1'b0);
    cyc("ill_t3", 3'd4, S_NONE, 1'b0);
    chk_err("ill_t3", 1'b0, 2'd0);
    cyc("ill_err", 3'd7, S_NONE, 1'b0);
    chk_err("ill_err", 1'b1, 2'd2);
    sif.run = 1'b0;
    cyc("ill_hold1", 3'd7, S_NONE, 1'b0);
    sif.run = 1'b1;
    cyc("ill_hold2", 3'd7, S_NONE, 1'b0);
    chk_err("ill_hold", 1'b1, 2'd2);
    chk_cnt("ill_hold", 32'd0);

    // Clear out of ERR.
    @(negedge clk);
    clr = 1'b1;
    @(negedge clk);
    chk("eclr_state", 32'(sif.t_state), 32'd0);
    chk_err("eclr", 1'b0, 2'd0);
    clr = 1'b0;
    sif.ir_opcode = OP_OUT;
    sif.mem_ready = 1'b1;

    // Two OUT instructions back to back.
    cyc("b2b_a_t0", 3'd1, S_T0, 1'b0);
    cyc("b2b_a_t1", 3'd2, S_T1F, 1'b0);
    cyc("b2b_a_t2", 3'd3, S_T2, 1'b0);
    cyc("b2b_a_t3", 3'd4, S_OUT, 1'b1);
    cyc("b2b_b_t0", 3'd1, S_T0, 1'b0);
    cyc("b2b_b_t1", 3'd2, S_T1F, 1'b0);
    cyc("b2b_b_t2", 3'd3, S_T2, 1'b0);
    cyc("b2b_b_t3", 3'd4, S_OUT, 1'b1);
    sif.mem_ready = 1'b0;

    // Timeout: 15 T1 cycles without mem_ready, then ERR code 1.
    cyc("tmo_t0", 3'd1, S_T0, 1'b0);
    chk_cnt("b2b", 32'd2);
    cyc("tmo_t1_1", 3'd2, S_T1F, 1'b0);
    for (int i = 2; i <= 15; i++) begin
      cyc($sformatf("tmo_t1_%0d", i), 3'd2, S_T1, 1'b0);
      chk_err($sformatf("tmo_t1_%0d", i), 1'b0, 2'd0);
    end
    cyc("tmo_err", 3'd7, S_NONE, 1'b0);
    chk_err("tmo_err", 1'b1, 2'd1);
    sif.mem_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cyc("tmo_hold", 3'd7, S_NONE, 1'b0);
    end
    chk_err("tmo_hold", 1'b1, 2'd1);

    #1;
    clr = 1'b1;
    #1;
    chk("end_state", 32'(sif.t_state), 32'd0);
    chk_err("end", 1'b0, 2'd0);
    chk_cnt("end", 32'd0);
    clr = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
